// File: rtl/seven_seg_display_pkg.sv
// Shared constants for the seven-segment readout: RV32I major opcodes and the
// active-low hexadecimal glyph table in {g,f,e,d,c,b,a} bit order.
package seven_seg_display_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned DATA_W     = NUM_DIGITS * NIBBLE_W;

  typedef logic [SEG_W-1:0] seg_t;
  typedef logic [6:0]       opcode_t;

  localparam opcode_t OPCODE_LOAD   = 7'b0000011;
  localparam opcode_t OPCODE_OP_IMM = 7'b0010011;
  localparam opcode_t OPCODE_AUIPC  = 7'b0010111;
  localparam opcode_t OPCODE_STORE  = 7'b0100011;
  localparam opcode_t OPCODE_OP     = 7'b0110011;
  localparam opcode_t OPCODE_LUI    = 7'b0110111;
  localparam opcode_t OPCODE_BRANCH = 7'b1100011;
  localparam opcode_t OPCODE_JALR   = 7'b1100111;
  localparam opcode_t OPCODE_JAL    = 7'b1101111;
  localparam opcode_t OPCODE_SYSTEM = 7'b1110011;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Index is the nibble value; a 0 bit lights the segment.
  localparam seg_t GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic seg_t glyph_of(input logic [NIBBLE_W-1:0] nibble);
    return GLYPH[nibble];
  endfunction

endpackage

// File: rtl/seven_seg_display_if.sv
// Data/opcode inputs and the eight static digit buses of the display driver.
interface seven_seg_display_if;
  import seven_seg_display_pkg::*;

  logic [DATA_W-1:0] bcd;
  opcode_t           opcode;
  seg_t              s1;
  seg_t              s2;
  seg_t              s3;
  seg_t              s4;
  seg_t              s5;
  seg_t              s6;
  seg_t              s7;
  seg_t              s8;

  modport master (
    output bcd, opcode,
    input  s1, s2, s3, s4, s5, s6, s7, s8
  );

  modport slave (
    input  bcd, opcode,
    output s1, s2, s3, s4, s5, s6, s7, s8
  );

endinterface

// File: rtl/seven_seg_display_hex_to_7seg.sv
// One hex digit decoder: nibble to active-low segments, forced dark when blanked.
module seven_seg_display_hex_to_7seg
  import seven_seg_display_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble_i,
  input  logic                blank_i,
  output seg_t                seg_o
);

  always_comb begin
    seg_o = glyph_of(nibble_i);
    if (blank_i) begin
      seg_o = SEG_BLANK;
    end
  end

endmodule

// File: rtl/seven_seg_display.sv
// Eight-digit static hex readout: latches bcd when the opcode matches DISP_OPCODE
// and decodes each nibble of the latched word onto its own digit bus.
module seven_seg_display
  import seven_seg_display_pkg::*;
#(
  parameter opcode_t DISP_OPCODE   = OPCODE_OP,
  parameter bit      ACTIVE_LOW    = 1'b1,
  parameter bit      BLANK_LEADING = 1'b0
) (
  input logic                clk,
  input logic                rst,
  seven_seg_display_if.slave bus
);

  logic [DATA_W-1:0]     bcd_q;
  logic [NUM_DIGITS-1:0] blank;
  seg_t                  seg_raw [NUM_DIGITS];
  seg_t                  seg_out [NUM_DIGITS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q <= '0;
    end else if (bus.opcode == DISP_OPCODE) begin
      bcd_q <= bus.bcd;
    end
  end

  // A digit goes dark only when it and every digit above it are zero; digit 0 never does.
  always_comb begin : blank_gen
    logic upper_zero;
    upper_zero = 1'b1;
    blank      = '0;
    for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
      upper_zero = upper_zero & (bcd_q[NIBBLE_W*k +: NIBBLE_W] == '0);
      blank[k]   = BLANK_LEADING & upper_zero;
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    seven_seg_display_hex_to_7seg u_hex (
      .nibble_i (bcd_q[NIBBLE_W*k +: NIBBLE_W]),
      .blank_i  (blank[k]),
      .seg_o    (seg_raw[k])
    );
    assign seg_out[k] = ACTIVE_LOW ? seg_raw[k] : ~seg_raw[k];
  end

  assign bus.s1 = seg_out[0];
  assign bus.s2 = seg_out[1];
  assign bus.s3 = seg_out[2];
  assign bus.s4 = seg_out[3];
  assign bus.s5 = seg_out[4];
  assign bus.s6 = seg_out[5];
  assign bus.s7 = seg_out[6];
  assign bus.s8 = seg_out[7];

endmodule

// File: tb/tb_seven_seg_display.sv
// Directed bench for seven_seg_display: default build, leading-blank build and
// active-high build run side by side on the same stimulus.
module tb_seven_seg_display;
  import seven_seg_display_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  seven_seg_display_if bus_n ();
  seven_seg_display_if bus_b ();
  seven_seg_display_if bus_i ();

  seven_seg_display #(
    .DISP_OPCODE   (OPCODE_OP),
    .ACTIVE_LOW    (1'b1),
    .BLANK_LEADING (1'b0)
  ) dut_n (
    .clk (clk),
    .rst (rst),
    .bus (bus_n)
  );

  seven_seg_display #(
    .DISP_OPCODE   (OPCODE_OP),
    .ACTIVE_LOW    (1'b1),
    .BLANK_LEADING (1'b1)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  seven_seg_display #(
    .DISP_OPCODE   (OPCODE_OP),
    .ACTIVE_LOW    (1'b0),
    .BLANK_LEADING (1'b0)
  ) dut_i (
    .clk (clk),
    .rst (rst),
    .bus (bus_i)
  );

  always #5 clk = ~clk;

  function automatic logic [55:0] pk(input logic [6:0] d8, d7, d6, d5, d4, d3, d2, d1);
    return {d8, d7, d6, d5, d4, d3, d2, d1};
  endfunction

  task automatic drive(input logic [6:0] op, input logic [31:0] d);
    bus_n.opcode = op;
    bus_n.bcd    = d;
    bus_b.opcode = op;
    bus_b.bcd    = d;
    bus_i.opcode = op;
    bus_i.bcd    = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // exp_n: default build, exp_b: leading-blank build; active-high build must be ~exp_n.
  task automatic check(input string tag, input logic [55:0] exp_n, input logic [55:0] exp_b);
    logic [55:0] obs;
    logic [55:0] exp_i;
    exp_i = ~exp_n;
    obs = {bus_n.s8, bus_n.s7, bus_n.s6, bus_n.s5, bus_n.s4, bus_n.s3, bus_n.s2, bus_n.s1};
    vectors++;
    assert (obs === exp_n) else begin
      miscompares++;
      $error("FAIL %s normal observed=%h expected=%h", tag, obs, exp_n);
    end
    obs = {bus_b.s8, bus_b.s7, bus_b.s6, bus_b.s5, bus_b.s4, bus_b.s3, bus_b.s2, bus_b.s1};
    vectors++;
    assert (obs === exp_b) else begin
      miscompares++;
      $error("FAIL %s blank observed=%h expected=%h", tag, obs, exp_b);
    end
    obs = {bus_i.s8, bus_i.s7, bus_i.s6, bus_i.s5, bus_i.s4, bus_i.s3, bus_i.s2, bus_i.s1};
    vectors++;
    assert (obs === exp_i) else begin
      miscompares++;
      $error("FAIL %s inverted observed=%h expected=%h", tag, obs, exp_i);
    end
  endtask

  initial begin
    logic [55:0] zero_n;
    logic [55:0] zero_b;
    logic [55:0] v91_n;
    logic [55:0] v91_b;
    logic [55:0] v12345678;
    zero_n    = pk(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);
    zero_b    = pk(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40);
    v91_n     = pk(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h10, 7'h79);
    v91_b     = pk(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h10, 7'h79);
    v12345678 = pk(7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00);

    // Reset asserted between edges, with a matching opcode present.
    drive(OPCODE_OP, 32'h1234_5678);
    #2 rst = 1'b1;
    #1 check("reset_async", zero_n, zero_b);
    step();
    check("reset_hold_a", zero_n, zero_b);
    step();
    check("reset_hold_b", zero_n, zero_b);

    rst = 1'b0;
    drive(OPCODE_OP, 32'h0000_0066);
    step();
    check("capture_66",
          pk(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h02, 7'h02),
          pk(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h02, 7'h02));

    drive(OPCODE_OP, 32'h0000_0078);
    step();
    check("seq_78",
          pk(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h78, 7'h00),
          pk(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78, 7'h00));

    drive(OPCODE_OP, 32'h0000_0067);
    step();
    check("seq_67",
          pk(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h02, 7'h78),
          pk(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h02, 7'h78));

    drive(OPCODE_OP, 32'h0000_0091);
    step();
    check("seq_91", v91_n, v91_b);

    // Input changes between edges must not reach the outputs.
    drive(OPCODE_OP, 32'h0000_0022);
    #2 check("between_edges", v91_n, v91_b);

    drive(OPCODE_OP_IMM, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_op_imm", v91_n, v91_b);
    end
    drive(7'b0110010, 32'hFFFF_FFFF);
    step();
    check("hold_bit0_diff", v91_n, v91_b);
    drive(7'b1110011, 32'hFFFF_FFFF);
    step();
    check("hold_bit6_diff", v91_n, v91_b);

    drive(OPCODE_OP, 32'h89AB_CDEF);
    step();
    check("full_hex_89abcdef",
          pk(7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E),
          pk(7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E));

    drive(OPCODE_OP, 32'h0123_4567);
    step();
    check("full_hex_01234567",
          pk(7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78),
          pk(7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78));

    drive(OPCODE_OP, 32'h0000_0105);
    step();
    check("blank_0105",
          pk(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h40, 7'h12),
          pk(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h12));

    drive(OPCODE_OP, 32'h0000_0000);
    step();
    check("blank_all_zero", zero_n, zero_b);

    drive(OPCODE_OP, 32'h8000_0000);
    step();
    check("blank_top_only",
          pk(7'h00, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40),
          pk(7'h00, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40));

    drive(OPCODE_OP, 32'h0000_0010);
    step();
    check("blank_s2_one",
          pk(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h40),
          pk(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40));

    // Mid-operation reset clears outputs without a clock edge.
    drive(OPCODE_OP, 32'h89AB_CDEF);
    step();
    #3 rst = 1'b1;
    #1 check("mid_reset", zero_n, zero_b);
    drive(OPCODE_OP, 32'h1234_5678);
    step();
    check("mid_reset_hold", zero_n, zero_b);
    rst = 1'b0;
    #1 check("release_pre_edge", zero_n, zero_b);
    step();
    check("release_capture", v12345678, v12345678);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
